// File: rtl/y_requant_fifo.sv
// Output stage after the convolution engine: optional ReLU, rounding arithmetic
// right shift and saturation to OUT_WIDTH, then a small FIFO toward the consumer.
module y_requant_fifo #(
  parameter int ACC_SIZE  = 18,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4,
  parameter int DEPTH     = 4,
  parameter int RELU      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid_y,
  output logic                 s_ready_y,
  input  logic [ACC_SIZE-1:0]  s_data_in_y,
  output logic                 m_valid_q,
  input  logic                 m_ready_q,
  output logic [OUT_WIDTH-1:0] m_data_out_q,
  output logic                 m_sat_q
);

  // Handshakes: a word moves on a port at a rising edge where valid && ready.
  // s_ready_y comes from registered occupancy only (never from m_ready_q), so a
  // full FIFO refuses a word even in a cycle where the head is being popped.

  localparam int AW = ACC_SIZE + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic signed [AW-1:0] RND   = AW'((2 ** SHIFT) / 2);
  localparam logic signed [AW-1:0] Q_MAX = AW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] Q_MIN = AW'(-(2 ** (OUT_WIDTH - 1)));

  logic signed [AW-1:0]  v;
  logic signed [AW-1:0]  r;
  logic [OUT_WIDTH-1:0]  q_data;
  logic                  q_sat;

  logic [OUT_WIDTH:0]    mem [DEPTH];
  logic [OUT_WIDTH:0]    head;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    v = signed'({s_data_in_y[ACC_SIZE-1], s_data_in_y});
    if (RELU != 0 && v[AW-1]) begin
      v = '0;
    end
    r      = (v + RND) >>> SHIFT;
    q_sat  = 1'b1;
    q_data = Q_MAX[OUT_WIDTH-1:0];
    if (r > Q_MAX) begin
      q_data = Q_MAX[OUT_WIDTH-1:0];
    end else if (r < Q_MIN) begin
      q_data = Q_MIN[OUT_WIDTH-1:0];
    end else begin
      q_data = r[OUT_WIDTH-1:0];
      q_sat  = 1'b0;
    end
  end

  assign s_ready_y = !reset && (count < CW'(DEPTH));
  assign m_valid_q = !reset && (count != '0);
  assign push      = s_valid_y && s_ready_y;
  assign pop       = m_valid_q && m_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; it is only observed while m_valid_q is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {q_sat, q_data};
  end

  assign head         = mem[rd_ptr];
  assign m_data_out_q = head[OUT_WIDTH-1:0];
  assign m_sat_q      = head[OUT_WIDTH];

endmodule
